// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - operand/result handshake bundle for serial_subtractor (ovf present with SERIAL_SUB_OVF_EN)
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (
    output start_valid, a, b, bin, result_ready,
    input  start_ready, result_valid, diff, bout, ovf
  );

  modport slave (
    input  start_valid, a, b, bin, result_ready,
    output start_ready, result_valid, diff, bout, ovf
  );
`else
  modport master (
    output start_valid, a, b, bin, result_ready,
    input  start_ready, result_valid, diff, bout
  );

  modport slave (
    input  start_valid, a, b, bin, result_ready,
    output start_ready, result_valid, diff, bout
  );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, LSB first, one full-subtractor cell; SERIAL_SUB_OVF_EN adds ovf
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             br;
  logic [CW-1:0]    cnt;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_r;
`endif

  logic a_i;
  logic b_i;
  logic d;
  logic br_next;

  // Single full-subtractor cell working on the current LSBs and the stored borrow
  always_comb begin
    a_i     = a_sh[0];
    b_i     = b_sh[0];
    d       = a_i ^ b_i ^ br;
    br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br);
  end

  // Handshake flags come straight from the state register, so no input reaches an output
  assign bus.start_ready  = (state == IDLE);
  assign bus.result_valid = (state == DONE);
  assign bus.diff         = diff_r;
  assign bus.bout         = bout_r;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf          = ovf_r;
`endif

  // Control FSM and serial datapath: capture in IDLE, one bit per cycle in RUN, hold in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      diff_r <= '0;
      bout_r <= 1'b0;
      br     <= 1'b0;
      cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            br    <= bus.bin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          diff_r <= {d, diff_r[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          br     <= br_next;
          if (cnt == LAST) begin
            // br here is the borrow into the MSB; with the borrow out it gives signed overflow
            bout_r <= br_next;
`ifdef SERIAL_SUB_OVF_EN
            ovf_r  <= br ^ br_next;
`endif
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.result_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
